load_store_unit: RTL

//  Initiator side of the byte-addressed data memory: turns MEM-stage load/store requests into memory accesses.

---
 rtl/load_store_unit_if.sv | 34 +++
 rtl/load_store_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Pipeline-request, response and data-memory signals of the load/store unit.
// master: the load_store_unit itself; slave: the pipeline/memory side.
interface load_store_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 32;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rd;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses to a 4-byte-write memory, sub-word stores via read-modify-write.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests complete at once with resp_err=1 and no memory access.
module load_store_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    load_store_unit_if.master    io_bus
);
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [1:0]        size;
        logic              uns;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    state_t            r_state;
    state_t            w_next;
    req_t              r_req;
    req_t              w_req_in;
    logic [DATA_W-1:0] r_word;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_load_ext;
    logic [DATA_W-1:0] w_merge;
    logic              w_accept;
    logic              w_in_word;
    logic              w_trap;

    assign w_accept  = io_bus.req_valid && (r_state == ST_IDLE);
    assign w_in_word = io_bus.req_size[1];

    assign w_req_in = '{
        we:    io_bus.req_we,
        size:  io_bus.req_size,
        uns:   io_bus.req_unsigned,
        addr:  io_bus.req_addr,
        wdata: io_bus.req_wdata
    };

`ifdef MISALIGN_TRAP_EN
    logic r_err;

    // Half needs addr[0]==0, word (size 10/11) needs addr[1:0]==0.
    assign w_trap = ((io_bus.req_size == 2'b01) && io_bus.req_addr[0]) ||
                    (w_in_word && (io_bus.req_addr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_trap;
        end
    end

    assign io_bus.resp_err = r_err;
`else
    assign w_trap          = 1'b0;
    assign io_bus.resp_err = 1'b0;
`endif

    // Sign/zero extension of the word currently presented on mem_rd.
    always_comb begin
        w_load_ext = io_bus.mem_rd;
        case (r_req.size)
            2'b00: begin
                if (r_req.uns) begin
                    w_load_ext = {24'h0, io_bus.mem_rd[7:0]};
                end else begin
                    w_load_ext = {{24{io_bus.mem_rd[7]}}, io_bus.mem_rd[7:0]};
                end
            end
            2'b01: begin
                if (r_req.uns) begin
                    w_load_ext = {16'h0, io_bus.mem_rd[15:0]};
                end else begin
                    w_load_ext = {{16{io_bus.mem_rd[15]}}, io_bus.mem_rd[15:0]};
                end
            end
            default: w_load_ext = io_bus.mem_rd;
        endcase
    end

    // Store word: new low bytes over the bytes read back in RD.
    always_comb begin
        w_merge = r_req.wdata;
        case (r_req.size)
            2'b00:   w_merge = {r_word[31:8], r_req.wdata[7:0]};
            2'b01:   w_merge = {r_word[31:16], r_req.wdata[15:0]};
            default: w_merge = r_req.wdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next            = r_state;
        io_bus.req_ready  = 1'b0;
        io_bus.resp_valid = 1'b0;
        io_bus.mem_addr   = '0;
        io_bus.mem_wd     = '0;
        io_bus.mem_we     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_bus.req_ready = 1'b1;
                if (w_accept) begin
                    if (w_trap) begin
                        w_next = ST_DONE;
                    end else if (io_bus.req_we && w_in_word) begin
                        w_next = ST_WR;
                    end else begin
                        w_next = ST_RD;
                    end
                end
            end
            ST_RD: begin
                io_bus.mem_addr = r_req.addr;
                w_next          = r_req.we ? ST_WR : ST_DONE;
            end
            ST_WR: begin
                io_bus.mem_addr = r_req.addr;
                io_bus.mem_wd   = w_merge;
                io_bus.mem_we   = !rst;
                w_next          = ST_DONE;
            end
            ST_DONE: begin
                io_bus.resp_valid = 1'b1;
                w_next            = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Request capture and read-data handling; rdata reads 0 for stores and traps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req   <= '0;
            r_word  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_req   <= w_req_in;
                r_rdata <= '0;
            end
            if (r_state == ST_RD) begin
                r_word  <= io_bus.mem_rd;
                r_rdata <= r_req.we ? '0 : w_load_ext;
            end
        end
    end

    assign io_bus.resp_rdata = r_rdata;

endmodule
